// File: rtl/aes_out_serializer_if.sv
// aes_out_serializer_if: block-in / word-out bus bundle for aes_out_serializer.
// slave is the serializer's view, master the engine/sink side.
interface aes_out_serializer_if #(parameter int DEPTH = 4);
   logic [127:0]                 blk_in;
   logic                         blk_valid;
   logic                         issue;
   logic                         issue_ok;
   logic [31:0]                  word_out;
   logic                         word_valid;
   logic                         word_ready;
   logic                         word_last;
   logic                         flush;
   logic [$clog2(DEPTH+1)-1:0]   occupancy;
   logic                         overflow;
   modport slave (
      input  blk_in, blk_valid, issue, word_ready, flush,
      output issue_ok, word_out, word_valid, word_last, occupancy, overflow
   );
   modport master (
      output blk_in, blk_valid, issue, word_ready, flush,
      input  issue_ok, word_out, word_valid, word_last, occupancy, overflow
   );
endinterface

// File: rtl/aes_out_serializer.sv
// aes_out_serializer: 128-bit block FIFO serialized MSW-first onto a 32-bit stream, with issue credits.
// Define AES_OUT_BYTE_SWAP_EN to byte-reverse every output word.
module aes_out_serializer #(
   parameter int DEPTH = 4,
   parameter int LAT   = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   aes_out_serializer_if.slave s_if
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 1 || LAT < 1) begin : g_bad_param
      $error("aes_out_serializer: DEPTH and LAT must be >= 1");
   end

   logic [127:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d, infl_q, infl_d;
   logic [1:0]    widx_q, widx_d;
   logic          ovf_q, ovf_d;
   logic          valid, pop, pop_last, full, wr, inc;
   logic [31:0]   word;
   logic [CW:0]   credit_sum;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign valid      = occ_q != '0;
   assign pop        = valid && s_if.word_ready;
   assign pop_last   = pop && widx_q == 2'd3;
   assign full       = occ_q == CW'(DEPTH);
   assign wr         = s_if.blk_valid && !s_if.flush && (!full || pop_last);
   assign credit_sum = {1'b0, infl_q} + {1'b0, occ_q};
   assign inc        = s_if.issue && s_if.issue_ok;
   assign word       = mem_q[rd_ptr_q][{~widx_q, 5'd0} +: 32];

   assign s_if.issue_ok   = credit_sum < (CW + 1)'(DEPTH);
   assign s_if.word_valid = valid;
   assign s_if.word_last  = valid && widx_q == 2'd3;
   assign s_if.occupancy  = occ_q;
   assign s_if.overflow   = ovf_q;
`ifdef AES_OUT_BYTE_SWAP_EN
   assign s_if.word_out = valid ? {word[7:0], word[15:8], word[23:16], word[31:24]} : '0;
`else
   assign s_if.word_out = valid ? word : '0;
`endif

   always_comb begin
      wr_ptr_d = s_if.flush ? '0 : wr ? nxt(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = s_if.flush ? '0 : pop_last ? nxt(rd_ptr_q) : rd_ptr_q;
      occ_d    = s_if.flush ? '0 : occ_q + CW'(wr) - CW'(pop_last);
      widx_d   = s_if.flush ? 2'd0 : pop ? widx_q + 2'd1 : widx_q;
      ovf_d    = !s_if.flush && (ovf_q || (s_if.blk_valid && full && !pop_last));
      // inflight saturates at 0: a block with no credit outstanding is still stored
      infl_d   = (inc && !s_if.blk_valid) ? infl_q + 1'b1 :
                 (!inc && s_if.blk_valid && infl_q != '0) ? infl_q - 1'b1 : infl_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         infl_q   <= '0;
         widx_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         infl_q   <= infl_d;
         widx_q   <= widx_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= s_if.blk_in;
   end
endmodule

// File: tb/tb_aes_out_serializer.sv
// tb_aes_out_serializer: directed checks of serialization, credits, overflow, flush, backpressure and reset.
module tb_aes_out_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   aes_out_serializer_if #(.DEPTH(4)) bus ();
   aes_out_serializer #(.DEPTH(4), .LAT(10)) dut (.clk(clk), .rst_n(rst_n), .s_if(bus));

   always #5 clk = ~clk;

   localparam logic [127:0] B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] C2 = 128'h11111111222222223333333344444444;
   localparam logic [127:0] C3 = 128'h55555555666666667777777788888888;
   localparam logic [127:0] D  = 128'hdeadbeefcafef00d0badc0de12345678;
   localparam logic [127:0] E  = 128'hffffffffeeeeeeeeddddddddcccccccc;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ew(input logic [127:0] b, input int i);
      logic [31:0] w;
      w = b[127 - 32*i -: 32];
`ifdef AES_OUT_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic put(input logic [127:0] b);
      bus.blk_valid = 1'b1;
      bus.blk_in    = b;
      tick();
      bus.blk_valid = 1'b0;
   endtask

   task automatic drain(input logic [127:0] b, input string tag);
      bus.word_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_valid"}, 128'(bus.word_valid), 128'd1);
         chk({tag, "_word"}, 128'(bus.word_out), 128'(ew(b, i)));
         chk({tag, "_last"}, 128'(bus.word_last), 128'(i == 3));
         tick();
      end
      bus.word_ready = 1'b0;
   endtask

   logic [127:0] h [5];
   logic [31:0]  q [$];

   initial begin
      bus.blk_in = '0; bus.blk_valid = 0; bus.issue = 0; bus.word_ready = 0; bus.flush = 0;
      repeat (3) tick();
      chk("rst_valid", 128'(bus.word_valid), 0);
      chk("rst_last", 128'(bus.word_last), 0);
      chk("rst_word", 128'(bus.word_out), 0);
      chk("rst_issue_ok", 128'(bus.issue_ok), 1);
      chk("rst_occ", 128'(bus.occupancy), 0);
      chk("rst_ovf", 128'(bus.overflow), 0);
      rst_n = 1'b1;
      tick();

      bus.word_ready = 1'b1;
      put(B);
      drain(B, "single");
      chk("single_empty", 128'(bus.word_valid), 0);
      chk("single_occ", 128'(bus.occupancy), 0);

      bus.issue = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("credit_ok_pre", 128'(bus.issue_ok), 1);
         tick();
      end
      bus.issue = 1'b0;
      chk("credit_ok_exhausted", 128'(bus.issue_ok), 0);
      put(C0); put(C1); put(C2); put(C3);
      chk("credit_occ4", 128'(bus.occupancy), 4);
      chk("credit_ok_full", 128'(bus.issue_ok), 0);
      drain(C0, "credit_pop");
      chk("credit_occ3", 128'(bus.occupancy), 3);
      chk("credit_ok_back", 128'(bus.issue_ok), 1);

      put(D);
      chk("ovf_occ_pre", 128'(bus.occupancy), 4);
      put(E);
      chk("ovf_set", 128'(bus.overflow), 1);
      chk("ovf_occ", 128'(bus.occupancy), 4);
      chk("ovf_head", 128'(bus.word_out), 128'(ew(C1, 0)));
      tick();
      chk("ovf_sticky", 128'(bus.overflow), 1);
      bus.flush = 1'b1;
      bus.blk_valid = 1'b1;
      bus.blk_in = E;
      tick();
      bus.flush = 1'b0;
      bus.blk_valid = 1'b0;
      chk("flush_ovf", 128'(bus.overflow), 0);
      chk("flush_occ", 128'(bus.occupancy), 0);
      chk("flush_valid", 128'(bus.word_valid), 0);
      chk("flush_issue_ok", 128'(bus.issue_ok), 1);

      put(C2); put(C3);
      for (int i = 0; i < 4; i++) q.push_back(ew(C2, i));
      for (int i = 0; i < 4; i++) q.push_back(ew(C3, i));
      for (int i = 0; i < 80 && q.size() > 0; i++) begin
         bus.word_ready = 1'($urandom_range(0, 1));
         chk("bp_valid", 128'(bus.word_valid), 1);
         chk("bp_word", 128'(bus.word_out), 128'(q[0]));
         chk("bp_last", 128'(bus.word_last), 128'(q.size() == 1 || q.size() == 5));
         if (bus.word_ready) void'(q.pop_front());
         tick();
      end
      bus.word_ready = 1'b0;
      chk("bp_drained", 128'(q.size()), 0);
      chk("bp_empty", 128'(bus.word_valid), 0);

      h[0] = C0; h[1] = C1; h[2] = D; h[3] = B; h[4] = E;
      for (int i = 0; i < 4; i++) put(h[i]);
      bus.word_ready = 1'b1;
      repeat (3) tick();
      chk("simul_last", 128'(bus.word_last), 1);
      put(h[4]);
      chk("simul_occ", 128'(bus.occupancy), 4);
      chk("simul_ovf", 128'(bus.overflow), 0);
      for (int i = 1; i < 5; i++) drain(h[i], "simul_drain");
      chk("simul_occ_end", 128'(bus.occupancy), 0);

      bus.word_ready = 1'b1;
      put(D);
      chk("mid_word0", 128'(bus.word_out), 128'(ew(D, 0)));
      tick();
      chk("mid_word1", 128'(bus.word_out), 128'(ew(D, 1)));
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 128'(bus.word_valid), 0);
      chk("arst_occ", 128'(bus.occupancy), 0);
      chk("arst_issue_ok", 128'(bus.issue_ok), 1);
      #3 rst_n = 1'b1;
      repeat (2) tick();
      chk("arst_after_valid", 128'(bus.word_valid), 0);
      chk("arst_after_occ", 128'(bus.occupancy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
